fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline CPU. Holds the program counter, addresses the word-organised instruction memory, and latches the fetched instruction with its PC+4 into the IF/ID register. The instruction decoder and control unit in ID consume that register. The stage handles hazard-unit stalls and taken-branch redirects resolved in ID, squashing the wrong-path instruction.

---
 rtl/fetch_stage.sv | 55 +++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// request, and the IF/ID pipeline register with stall and branch-squash handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  output logic [31:0]            PC,
  output logic [31:0]            IF_ID_Inst,
  output logic [31:0]            IF_ID_PCPlus4,
  output logic                   IF_ID_Valid,
  output logic [31:0]            fetch_count
);

  logic [31:0] pc_plus4;

  assign pc_plus4  = PC + 32'd4;
  assign imem_addr = PC[IMEM_ADDR_W+1:2];

  // A stall outranks a redirect: ID's branch compare is stale while it is held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      PC            <= RESET_PC;
      IF_ID_Inst    <= 32'h0;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
      fetch_count   <= 32'h0;
    end else if (stall) begin
      PC            <= PC;
      IF_ID_Inst    <= IF_ID_Inst;
      IF_ID_PCPlus4 <= IF_ID_PCPlus4;
      IF_ID_Valid   <= IF_ID_Valid;
      fetch_count   <= fetch_count;
    end else if (branch_taken) begin
      PC            <= branch_target & 32'hFFFF_FFFC;
      IF_ID_Inst    <= 32'h0;
      IF_ID_PCPlus4 <= 32'h0;
      IF_ID_Valid   <= 1'b0;
      fetch_count   <= fetch_count;
    end else begin
      PC            <= pc_plus4;
      IF_ID_Inst    <= imem_data;
      IF_ID_PCPlus4 <= pc_plus4;
      IF_ID_Valid   <= 1'b1;
      fetch_count   <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model pushes the expected
// post-edge state onto a scoreboard queue, popped and compared after each edge.
module tb_fetch_stage;

  localparam int AW = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic [31:0] cnt;
    logic        valid;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   PC;
  logic [31:0]   IF_ID_Inst;
  logic [31:0]   IF_ID_PCPlus4;
  logic          IF_ID_Valid;
  logic [31:0]   fetch_count;

  logic [31:0] mem [256];

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pp4;
  logic [31:0] m_cnt;
  logic        m_valid;

  exp_t sb [$];
  int   vectors;
  int   miscompares;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .PC            (PC),
    .IF_ID_Inst    (IF_ID_Inst),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .fetch_count   (fetch_count)
  );

  assign imem_data = mem[imem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, push the expectation, then
  // pop and compare once the edge has passed.
  task automatic applyStimulus(input logic rst_n, input logic st, input logic br,
                               input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    reset         = rst_n;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (!rst_n) begin
      m_pc = 32'h0; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (st) begin
      // everything holds
    end else if (br) begin
      m_pc = {tgt[31:2], 2'b00}; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_inst  = mem[m_pc[AW+1:2]];
      m_pp4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    e.pc = m_pc; e.inst = m_inst; e.pp4 = m_pp4; e.cnt = m_cnt; e.valid = m_valid;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    checkOutput("pc",       PC,                   got.pc);
    checkOutput("inst",     IF_ID_Inst,           got.inst);
    checkOutput("pcplus4",  IF_ID_PCPlus4,        got.pp4);
    checkOutput("valid",    {31'h0, IF_ID_Valid}, {31'h0, got.valid});
    checkOutput("count",    fetch_count,          got.cnt);
    checkOutput("imemaddr", {24'h0, imem_addr},   {24'h0, got.pc[AW+1:2]});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
    mem[0]  = 32'hAAAA_0001;
    mem[1]  = 32'hBBBB_0002;
    mem[2]  = 32'hCCCC_0003;
    mem[3]  = 32'hDDDD_0004;
    mem[16] = 32'h1616_1616;
    m_pc = 32'h0; m_inst = 32'h0; m_pp4 = 32'h0; m_cnt = 32'h0; m_valid = 1'b0;

    // Reset held for two edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resetPc", PC, 32'h0);

    // A, B, then a 3-cycle stall while C is being fetched, then C, D.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("seqA", IF_ID_Inst, 32'hAAAA_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("stallInst", IF_ID_Inst, 32'hBBBB_0002);
      checkOutput("stallPc",   PC,         32'h8);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("seqC",    IF_ID_Inst,    32'hCCCC_0003);
    checkOutput("seqCpp4", IF_ID_PCPlus4, 32'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("seqD",     IF_ID_Inst,    32'hDDDD_0004);
    checkOutput("seqDpp4",  IF_ID_PCPlus4, 32'd16);
    checkOutput("seqCount", fetch_count,   32'd4);

    // Back to PC=8, then branch to 0x43 (low bits dropped -> 0x40).
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h43);
    checkOutput("brPc",    PC,                   32'h40);
    checkOutput("brValid", {31'h0, IF_ID_Valid}, 32'h0);
    checkOutput("brCount", fetch_count,          32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("brTgtInst", IF_ID_Inst,    32'h1616_1616);
    checkOutput("brTgtPp4",  IF_ID_PCPlus4, 32'h44);
    checkOutput("brTgtCnt",  fetch_count,   32'd5);

    // Stall beats branch; the redirect happens once the stall drops.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("stBrPc", PC, 32'h44);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
    checkOutput("stBrRedirect", PC, 32'h100);

    // Randomised mix of stalls, branches and plain fetches.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    $urandom);
    end

    // Wrap at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("wrapStart", PC, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrapPc",   PC,            32'h0);
    checkOutput("wrapPp4",  IF_ID_PCPlus4, 32'h0);
    checkOutput("wrapInst", IF_ID_Inst,    mem[255]);

    // Reset during a stall, then during a branch.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rstStallPc",    PC,                   32'h0);
    checkOutput("rstStallValid", {31'h0, IF_ID_Valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    checkOutput("rstBrPc",    PC,          32'h0);
    checkOutput("rstBrCount", fetch_count, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("postRstInst", IF_ID_Inst, 32'hAAAA_0001);

    checkOutput("sbEmpty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
